// File: rtl/wdt_pkg.sv
// Watchdog MMIO peripheral shared definitions:
// register offsets, kick key, access size, FSM states, bit indices.
package wdt_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_LOAD   = 5'h04;
  localparam logic [4:0] OFF_KICK   = 5'h08;
  localparam logic [4:0] OFF_COUNT  = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;

  localparam logic [31:0] WIN_SIZE = 32'h14;
  localparam logic [31:0] KICK_KEY = 32'h5A5A_A5A5;
  localparam logic [2:0]  SIZE_WORD = 3'b010;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_LOCK   = 2;

  localparam int ST_IRQ     = 0;
  localparam int ST_BADKICK = 1;
  localparam int ST_BUSERR  = 2;

  typedef enum logic [2:0] {
    DISABLED,
    RUNNING,
    WARNING,
    BITE,
    HALTED
  } wdt_state_e;

endpackage

// File: rtl/wdt_mmio_responder_counter.sv
// Watchdog prescaler plus 32-bit down counter.
// In: clk, rst_n, reload, reload_val, run. Out: count, expire.
module wdt_counter #(
  parameter logic [31:0] DEFAULT_LOAD = 32'd1000,
  parameter logic [15:0] PRESCALE     = 16'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reload,
  input  logic [31:0] reload_val,
  input  logic        run,
  output logic [31:0] count,
  output logic        expire
);

  logic [15:0] presc_q, presc_d;
  logic [31:0] count_q, count_d;
  logic        tick;

  assign tick   = run && (presc_q == PRESCALE - 16'd1);
  assign expire = tick && (count_q == 32'd0);
  assign count  = count_q;

  // An expiring tick leaves the count at zero; the parent
  // decides whether to reload it.
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    if (reload) begin
      presc_d = 16'd0;
      count_d = reload_val;
    end else if (tick) begin
      presc_d = 16'd0;
      if (count_q != 32'd0)
        count_d = count_q - 32'd1;
    end else if (run) begin
      presc_d = presc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= 16'd0;
      count_q <= DEFAULT_LOAD;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wdt_mmio_responder.sv
// Watchdog MMIO responder: decodes word loads/stores, holds CTRL/LOAD/STATUS,
// runs an irq-then-reset timeout. Ports: bus (addr,wdata,wd_en,rd_en,op_sel,
// hit,rdata) and watchdog outputs (wdt_irq, wdt_reset_req).
module wdt_mmio_responder
  import wdt_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter logic [31:0] DEFAULT_LOAD = 32'd1000,
  parameter logic [15:0] PRESCALE     = 16'd1,
  parameter logic [7:0]  RST_PULSE    = 8'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wd_en,
  input  logic        rd_en,
  input  logic [2:0]  op_sel,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        wdt_irq,
  output logic        wdt_reset_req
);

  wdt_state_e  state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [2:0]  status_q, status_d;
  logic [31:0] load_q, load_d;
  logic [7:0]  pulse_q, pulse_d;

  logic [31:0] off;
  logic [4:0]  off5;
  logic        word_ok, wr_ok, bus_err_set;
  logic        kick_wr, kick_good, kick_bad, kick_reload;
  logic        ctrl_wr, load_wr, active;
  logic        start, stop, irq_set;
  logic        cnt_reload, cnt_run, expire;
  logic [31:0] count;

  assign off  = addr - BASE_ADDR;
  assign off5 = off[4:0];
  assign hit  = (addr >= BASE_ADDR) && (off < WIN_SIZE)
             && (addr[1:0] == 2'b00);

  assign word_ok     = (op_sel == SIZE_WORD);
  assign wr_ok       = hit && wd_en && word_ok;
  assign bus_err_set = hit && (wd_en || rd_en) && !word_ok;

  assign kick_wr   = wr_ok && (off5 == OFF_KICK);
  assign kick_good = kick_wr && (wdata == KICK_KEY);
  assign kick_bad  = kick_wr && (wdata != KICK_KEY);

  assign ctrl_wr = wr_ok && (off5 == OFF_CTRL) && !ctrl_q[CTRL_LOCK];
  assign load_wr = wr_ok && (off5 == OFF_LOAD) && !ctrl_q[CTRL_LOCK];

  assign active      = (state_q == RUNNING) || (state_q == WARNING);
  assign kick_reload = active && kick_good;
  assign start = (state_q == DISABLED) && ctrl_wr
              && wdata[CTRL_EN] && !ctrl_q[CTRL_EN];
  assign stop  = active && ctrl_wr && !wdata[CTRL_EN];

  // Holding run low on a disable write freezes COUNT in that cycle.
  assign cnt_run    = active && !stop;
  assign irq_set    = (state_q == RUNNING) && expire && !kick_reload;
  assign cnt_reload = start || kick_reload || irq_set;

  wdt_counter #(
    .DEFAULT_LOAD(DEFAULT_LOAD),
    .PRESCALE    (PRESCALE)
  ) u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .reload    (cnt_reload),
    .reload_val(load_d),
    .run       (cnt_run),
    .count     (count),
    .expire    (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= DISABLED;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DISABLED: if (start) state_d = RUNNING;
      RUNNING, WARNING: begin
        if (kick_reload)
          state_d = RUNNING;
        else if (stop)
          state_d = DISABLED;
        else if (expire)
          state_d = (state_q == RUNNING) ? WARNING : BITE;
      end
      BITE: if (pulse_q == RST_PULSE - 8'd1) state_d = HALTED;
      HALTED: state_d = HALTED;
      default: state_d = DISABLED;
    endcase
  end

  always_comb begin
    wdt_reset_req = (state_q == BITE);
    wdt_irq       = status_q[ST_IRQ] && ctrl_q[CTRL_IRQ_EN];
  end

  // Set sources are applied after W1C so a same-cycle set wins.
  always_comb begin
    ctrl_d   = ctrl_q;
    load_d   = load_q;
    status_d = status_q;
    pulse_d  = (state_q == BITE) ? pulse_q + 8'd1 : 8'd0;
    if (ctrl_wr) ctrl_d = wdata[2:0];
    if (load_wr) load_d = wdata;
    if (wr_ok && (off5 == OFF_STATUS))
      status_d = status_q & ~wdata[2:0];
    if (irq_set)     status_d[ST_IRQ]     = 1'b1;
    if (kick_bad)    status_d[ST_BADKICK] = 1'b1;
    if (bus_err_set) status_d[ST_BUSERR]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q   <= 3'd0;
      load_q   <= DEFAULT_LOAD;
      status_q <= 3'd0;
      pulse_q  <= 8'd0;
    end else begin
      ctrl_q   <= ctrl_d;
      load_q   <= load_d;
      status_q <= status_d;
      pulse_q  <= pulse_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (hit && rd_en) begin
      case (off5)
        OFF_CTRL:   rdata = {29'd0, ctrl_q};
        OFF_LOAD:   rdata = load_q;
        OFF_COUNT:  rdata = count;
        OFF_STATUS: rdata = {29'd0, status_q};
        default:    rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_wdt_mmio_responder.sv
// Self-checking bench for wdt_mmio_responder: vector table, directed
// multi-cycle sequences and randomized traffic against a reference model.
module tb_wdt_mmio_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] KEY  = 32'h5A5A_A5A5;
  localparam int PULSE = 4;

  localparam int M_DIS  = 0;
  localparam int M_RUN  = 1;
  localparam int M_WARN = 2;
  localparam int M_BITE = 3;
  localparam int M_HALT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        wd_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [2:0]  op_sel = 3'b010;
  logic        hit;
  logic [31:0] rdata;
  logic        wdt_irq;
  logic        wdt_reset_req;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wdt_mmio_responder #(
    .BASE_ADDR   (BASE),
    .DEFAULT_LOAD(32'd1000),
    .PRESCALE    (16'd1),
    .RST_PULSE   (8'd4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .wdata        (wdata),
    .wd_en        (wd_en),
    .rd_en        (rd_en),
    .op_sel       (op_sel),
    .hit          (hit),
    .rdata        (rdata),
    .wdt_irq      (wdt_irq),
    .wdt_reset_req(wdt_reset_req)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic        re;
    logic [2:0]  op;
    logic        eh;
    logic [31:0] er;
  } vec_t;

  vec_t tbl[16];

  // reference model state
  int          m_mode;
  int          m_left;
  logic [2:0]  m_ctrl;
  logic [2:0]  m_st;
  logic [31:0] m_load;
  logic [31:0] m_count;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic we, input logic re,
                       input logic [2:0] op);
    addr = a;
    wdata = d;
    wd_en = we;
    rd_en = re;
    op_sel = op;
  endtask

  task automatic idle();
    drive(32'd0, 32'd0, 1'b0, 1'b0, 3'b010);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    drive(BASE + off, d, 1'b1, 1'b0, 3'b010);
    tick();
    idle();
  endtask

  task automatic rd(input string nm, input logic [31:0] off,
                    input logic [31:0] exp);
    drive(BASE + off, 32'd0, 1'b0, 1'b1, 3'b010);
    #1;
    chk(nm, rdata, exp);
    idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    m_mode = M_DIS;
    m_left = 0;
    m_ctrl = 3'd0;
    m_st = 3'd0;
    m_load = 32'd1000;
    m_count = 32'd1000;
  endtask

  function automatic logic f_hit(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'd20) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] f_reg(input logic [31:0] off);
    case (off)
      32'd0:   return {29'd0, m_ctrl};
      32'd4:   return m_load;
      32'd12:  return m_count;
      32'd16:  return {29'd0, m_st};
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the watchdog, from the register-map rules.
  task automatic model_step();
    logic [31:0] off;
    logic ww, berr, good, badk, ctl, ldw;
    logic [2:0] clr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    off = addr - BASE;
    ww = f_hit(addr) && wd_en && (op_sel == 3'b010);
    berr = f_hit(addr) && (wd_en || rd_en) && (op_sel != 3'b010);
    good = ww && (off == 32'd8) && (wdata == KEY);
    badk = ww && (off == 32'd8) && (wdata != KEY);
    ctl = ww && (off == 32'd0) && !m_ctrl[2];
    ldw = ww && (off == 32'd4) && !m_ctrl[2];
    clr = (ww && off == 32'd16) ? wdata[2:0] : 3'd0;
    m_st = m_st & ~clr;
    if (badk) m_st[1] = 1'b1;
    if (berr) m_st[2] = 1'b1;
    case (m_mode)
      M_DIS: begin
        if (ctl && wdata[0]) begin
          m_count = m_load;
          m_mode = M_RUN;
        end
      end
      M_RUN, M_WARN: begin
        if (good) begin
          m_count = m_load;
          m_mode = M_RUN;
        end else if (ctl && !wdata[0]) begin
          m_mode = M_DIS;
        end else if (m_count == 32'd0) begin
          if (m_mode == M_RUN) begin
            m_st[0] = 1'b1;
            m_count = m_load;
            m_mode = M_WARN;
          end else begin
            m_mode = M_BITE;
            m_left = PULSE;
          end
        end else begin
          m_count = m_count - 32'd1;
        end
      end
      M_BITE: begin
        m_left--;
        if (m_left == 0) m_mode = M_HALT;
      end
      default: ;
    endcase
    if (ctl) m_ctrl = wdata[2:0];
    if (ldw) m_load = wdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hi;
    int viol;
    logic [31:0] off;
    logic [31:0] d;
    logic [31:0] er;
    int kind;

    // ---------------- reset state + vector table ----------------
    tbl[0]  = '{BASE + 32'h0C, 32'd0, 1'b0, 1'b1, 3'b010, 1'b1, 32'd1000};
    tbl[1]  = '{BASE + 32'h10, 32'd0, 1'b0, 1'b1, 3'b010, 1'b1, 32'd0};
    tbl[2]  = '{BASE + 32'h00, 32'd0, 1'b0, 1'b1, 3'b010, 1'b1, 32'd0};
    tbl[3]  = '{BASE + 32'h04, 32'd0, 1'b0, 1'b1, 3'b010, 1'b1, 32'd1000};
    tbl[4]  = '{BASE + 32'h08, 32'd0, 1'b0, 1'b1, 3'b010, 1'b1, 32'd0};
    tbl[5]  = '{BASE + 32'h00, 32'd3, 1'b1, 1'b0, 3'b000, 1'b1, 32'd0};
    tbl[6]  = '{BASE + 32'h10, 32'd0, 1'b0, 1'b1, 3'b010, 1'b1, 32'd4};
    tbl[7]  = '{BASE + 32'h10, 32'd4, 1'b1, 1'b0, 3'b010, 1'b1, 32'd0};
    tbl[8]  = '{BASE + 32'h10, 32'd0, 1'b0, 1'b1, 3'b010, 1'b1, 32'd0};
    tbl[9]  = '{BASE + 32'h20, 32'd0, 1'b0, 1'b1, 3'b010, 1'b0, 32'd0};
    tbl[10] = '{BASE + 32'h02, 32'd0, 1'b0, 1'b1, 3'b010, 1'b0, 32'd0};
    tbl[11] = '{BASE + 32'h14, 32'd0, 1'b0, 1'b1, 3'b010, 1'b0, 32'd0};
    tbl[12] = '{BASE - 32'h04, 32'd0, 1'b0, 1'b1, 3'b010, 1'b0, 32'd0};
    tbl[13] = '{BASE + 32'h0C, 32'd0, 1'b0, 1'b1, 3'b001, 1'b1, 32'd1000};
    tbl[14] = '{BASE + 32'h10, 32'd0, 1'b0, 1'b1, 3'b010, 1'b1, 32'd4};
    tbl[15] = '{BASE + 32'h00, 32'd0, 1'b0, 1'b1, 3'b010, 1'b1, 32'd0};

    do_reset();
    chk("rst_irq", 32'(wdt_irq), 32'd0);
    chk("rst_req", 32'(wdt_reset_req), 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].a, tbl[i].d, tbl[i].we, tbl[i].re, tbl[i].op);
      #1;
      chk($sformatf("vec%0d_hit", i), 32'(hit), 32'(tbl[i].eh));
      chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].er);
      tick();
    end
    idle();

    // ---------------- full expiry: irq, then bite, then halt ----------------
    do_reset();
    wr(32'h04, 32'd5);
    wr(32'h00, 32'd3);
    for (int k = 0; k < 6; k++) begin
      rd($sformatf("exp_cnt%0d", k), 32'h0C, 32'(5 - k));
      chk($sformatf("exp_noirq%0d", k), 32'(wdt_irq), 32'd0);
      tick();
    end
    chk("exp_irq", 32'(wdt_irq), 32'd1);
    rd("exp_reload", 32'h0C, 32'd5);
    for (int k = 1; k < 6; k++) begin
      tick();
      chk($sformatf("warn_noreq%0d", k), 32'(wdt_reset_req), 32'd0);
      rd($sformatf("warn_cnt%0d", k), 32'h0C, 32'(5 - k));
    end
    tick();
    chk("bite_start", 32'(wdt_reset_req), 32'd1);
    hi = 1;
    for (int j = 0; j < 9; j++) begin
      tick();
      hi += int'(wdt_reset_req);
    end
    chk("bite_len", 32'(hi), 32'd4);
    wr(32'h08, KEY);
    chk("halt_req", 32'(wdt_reset_req), 32'd0);
    chk("halt_irq", 32'(wdt_irq), 32'd1);
    rd("halt_cnt", 32'h0C, 32'd0);

    // ---------------- LOAD=0, then reset during BITE ----------------
    do_reset();
    wr(32'h04, 32'd0);
    wr(32'h00, 32'd3);
    tick();
    chk("ld0_irq", 32'(wdt_irq), 32'd1);
    chk("ld0_noreq", 32'(wdt_reset_req), 32'd0);
    tick();
    chk("ld0_bite", 32'(wdt_reset_req), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rstbite_req", 32'(wdt_reset_req), 32'd0);
    chk("rstbite_irq", 32'(wdt_irq), 32'd0);
    rst_n = 1'b1;
    rd("rstbite_cnt", 32'h0C, 32'd1000);
    rd("rstbite_load", 32'h04, 32'd1000);
    rd("rstbite_ctrl", 32'h00, 32'd0);
    rd("rstbite_st", 32'h10, 32'd0);

    // ---------------- periodic kicks, then a bad key ----------------
    do_reset();
    wr(32'h04, 32'd5);
    wr(32'h00, 32'd3);
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 4 == 0) drive(BASE + 32'h08, KEY, 1'b1, 1'b0, 3'b010);
      else idle();
      tick();
      idle();
      if (wdt_irq || wdt_reset_req) viol++;
    end
    chk("kick_viol", 32'(viol), 32'd0);
    wr(32'h08, KEY);
    wr(32'h08, 32'h1234_5678);
    rd("badkick_cnt", 32'h0C, 32'd4);
    tick();
    rd("badkick_st", 32'h10, 32'd2);

    // ---------------- lock ----------------
    do_reset();
    wr(32'h04, 32'd50);
    wr(32'h00, 32'd5);
    wr(32'h00, 32'd0);
    wr(32'h04, 32'd99);
    rd("lock_cnt", 32'h0C, 32'd48);
    tick();
    rd("lock_ctrl", 32'h00, 32'd5);
    tick();
    rd("lock_load", 32'h04, 32'd50);
    wr(32'h08, KEY);
    rd("lock_kick", 32'h0C, 32'd50);

    // ---------------- kick on the WARNING expiry tick ----------------
    do_reset();
    wr(32'h04, 32'd3);
    wr(32'h00, 32'd3);
    repeat (7) tick();
    chk("wk_irq", 32'(wdt_irq), 32'd1);
    rd("wk_zero", 32'h0C, 32'd0);
    wr(32'h08, KEY);
    chk("wk_noreq", 32'(wdt_reset_req), 32'd0);
    rd("wk_cnt", 32'h0C, 32'd3);
    repeat (4) tick();
    chk("wk_running", 32'(wdt_reset_req), 32'd0);
    rd("wk_rewarn", 32'h0C, 32'd3);

    // ---------------- randomized traffic vs model ----------------
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      case ($urandom % 10)
        0, 1:    off = 32'h00;
        2:       off = 32'h04;
        3, 4:    off = 32'h08;
        5:       off = 32'h0C;
        6:       off = 32'h10;
        7:       off = 32'h14;
        8:       off = 32'h20;
        default: off = 32'h02;
      endcase
      case (off)
        32'h00: d = {29'd0, 1'($urandom % 24 == 0),
                     1'($urandom % 2), 1'($urandom % 4 != 0)};
        32'h04: d = $urandom % 8;
        32'h08: d = ($urandom % 4 != 0) ? KEY : $urandom;
        default: d = $urandom;
      endcase
      kind = $urandom % 10;
      drive(BASE + off, d, kind >= 7, kind >= 4 && kind < 7,
            ($urandom % 8 == 0) ? 3'($urandom % 8) : 3'b010);
      rst_n = ($urandom % 200 == 0) ? 1'b0 : 1'b1;
      #1;
      er = (f_hit(addr) && rd_en) ? f_reg(off) : 32'd0;
      chk("rnd_hit", 32'(hit), 32'(f_hit(addr)));
      chk("rnd_rdata", rdata, er);
      chk("rnd_irq", 32'(wdt_irq), 32'(m_st[0] & m_ctrl[1]));
      chk("rnd_req", 32'(wdt_reset_req), 32'(m_mode == M_BITE));
      tick();
      model_step();
    end
    rst_n = 1'b1;
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
